// File: rtl/marquee_pkg.sv
// Shared definitions for the marquee scan driver: run-time mode encoding.
package marquee_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC   = 2'b00;
    localparam mode_t MODE_SCROLL_L = 2'b01;
    localparam mode_t MODE_SCROLL_R = 2'b10;
    localparam mode_t MODE_BLINK    = 2'b11;

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter advancing on enable; tick marks the enabled terminal-count cycle.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Combinational so the consumer acts on the same edge the counter wraps.
    assign tick = enable && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (enable) begin
            if (cnt_reg == LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/marquee_scan_driver.sv
// Row-multiplexed LED matrix driver showing a COLS-wide window of a wider message buffer,
// with static, scroll-left, scroll-right and blink modes plus a host column-write port.
module marquee_scan_driver
    import marquee_pkg::*;
#(
    parameter int ROWS     = 5,
    parameter int COLS     = 7,
    parameter int MSG_COLS = 16,
    parameter int SCAN_DIV = 1000,
    parameter int STEP_DIV = 50
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  mode_t                       mode,
    input  logic                        wr_en,
    input  logic [$clog2(MSG_COLS)-1:0] wr_addr,
    input  logic [ROWS-1:0]             wr_data,
    output logic [ROWS-1:0]             L,
    output logic [COLS-1:0]             C,
    output logic                        frame_tick,
    output logic [$clog2(MSG_COLS)-1:0] offset
);

    localparam int AW = $clog2(MSG_COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [AW-1:0] OFF_LAST = AW'(MSG_COLS - 1);
    localparam logic [AW:0]   MSG_LEN  = (AW + 1)'(MSG_COLS);

    logic                scan_tick;
    logic                step_tick;
    logic [RW-1:0]       row_reg;
    logic                frame_tick_reg;
    logic [AW-1:0]       offset_reg;
    logic                blank_reg;
    logic [ROWS-1:0]     l_reg;
    logic [COLS-1:0]     c_reg;
    logic [ROWS-1:0]     l_next;
    logic [COLS-1:0]     c_next;
    logic [ROWS-1:0]     col_buf_reg [MSG_COLS];

    tick_divider #(
        .DIV(SCAN_DIV)
    ) u_scan_div (
        .clk   (CLK),
        .srst  (RST),
        .enable(1'b1),
        .tick  (scan_tick)
    );

    // Counts whole frames; its tick is the step event for scroll and blink.
    tick_divider #(
        .DIV(STEP_DIV)
    ) u_step_div (
        .clk   (CLK),
        .srst  (RST),
        .enable(frame_tick_reg),
        .tick  (step_tick)
    );

    // Addresses beyond MSG_COLS-1 match no column and are dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < MSG_COLS; i++) begin
                col_buf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MSG_COLS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    col_buf_reg[i] <= wr_data;
                end
            end
        end
    end

    // Visible column j shows buffer column (offset + j) mod MSG_COLS; one subtract
    // suffices since offset < MSG_COLS and j < COLS <= MSG_COLS.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_vis
            logic [AW:0]     sum;
            logic [AW-1:0]   idx;
            logic [ROWS-1:0] col_bits;

            assign sum      = {1'b0, offset_reg} + (AW + 1)'(gi);
            assign idx      = AW'((sum >= MSG_LEN) ? (sum - MSG_LEN) : sum);
            assign col_bits = col_buf_reg[idx];
            assign c_next[gi] = ~blank_reg & col_bits[row_reg];
        end
    endgenerate

    assign l_next = ROWS'(1) << row_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_reg        <= '0;
            frame_tick_reg <= 1'b0;
            offset_reg     <= '0;
            blank_reg      <= 1'b0;
            l_reg          <= '0;
            c_reg          <= '0;
        end else begin
            frame_tick_reg <= scan_tick && (row_reg == ROW_LAST);

            if (scan_tick) begin
                row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end

            if (step_tick) begin
                case (mode)
                    MODE_SCROLL_L: offset_reg <= (offset_reg == OFF_LAST) ? '0 : offset_reg + 1'b1;
                    MODE_SCROLL_R: offset_reg <= (offset_reg == '0) ? OFF_LAST : offset_reg - 1'b1;
                    default:       offset_reg <= offset_reg;
                endcase
            end

            if (mode != MODE_BLINK) begin
                blank_reg <= 1'b0;
            end else if (step_tick) begin
                blank_reg <= ~blank_reg;
            end

            l_reg <= l_next;
            c_reg <= c_next;
        end
    end

    assign L          = l_reg;
    assign C          = c_reg;
    assign frame_tick = frame_tick_reg;
    assign offset     = offset_reg;

endmodule

// File: tb/tb_marquee_scan_driver.sv
// Bench for marquee_scan_driver: two instances (STEP_DIV 1 and 2) against a cycle-count reference model.
module tb_marquee_scan_driver;
    import marquee_pkg::*;

    localparam int ROWS     = 5;
    localparam int COLS     = 7;
    localparam int MSG_COLS = 8;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = ROWS * SCAN_DIV;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] mask;
        int         steps;
        int         exp_off;
        logic [6:0] exp_c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_data = '0;

    logic [4:0] l_a, l_b;
    logic [6:0] c_a, c_b;
    logic       ft_a, ft_b;
    logic [2:0] off_a, off_b;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    marquee_scan_driver #(
        .ROWS(ROWS), .COLS(COLS), .MSG_COLS(MSG_COLS), .SCAN_DIV(SCAN_DIV), .STEP_DIV(1)
    ) dut_a (
        .CLK(clk), .RST(rst), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .L(l_a), .C(c_a), .frame_tick(ft_a), .offset(off_a)
    );

    marquee_scan_driver #(
        .ROWS(ROWS), .COLS(COLS), .MSG_COLS(MSG_COLS), .SCAN_DIV(SCAN_DIV), .STEP_DIV(2)
    ) dut_b (
        .CLK(clk), .RST(rst), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .L(l_b), .C(c_b), .frame_tick(ft_b), .offset(off_b)
    );

    // Reference model: everything derived from the number of edges since reset release.
    int         m_cyc   [2];
    int         m_off   [2];
    bit         m_blank [2];
    logic [4:0] m_l     [2];
    logic [6:0] m_c     [2];
    logic       m_ft    [2];
    logic [4:0] m_buf   [MSG_COLS];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_cyc[k] = 0; m_off[k] = 0; m_blank[k] = 0;
                m_l[k] = '0; m_c[k] = '0; m_ft[k] = 1'b0;
            end
            for (int c = 0; c < MSG_COLS; c++) m_buf[c] = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int row;
                int frames;
                bit step;
                row = (m_cyc[k] / SCAN_DIV) % ROWS;
                m_l[k] = '0;
                m_l[k][row] = 1'b1;
                for (int j = 0; j < COLS; j++) begin
                    logic [4:0] colv;
                    colv = m_buf[(m_off[k] + j) % MSG_COLS];
                    m_c[k][j] = m_blank[k] ? 1'b0 : colv[row];
                end
                m_ft[k] = ((m_cyc[k] + 1) % FRAME) == 0;
                frames = m_cyc[k] / FRAME;
                step = (m_cyc[k] > 0) && (m_cyc[k] % FRAME == 0) && (frames % (k + 1) == 0);
                if (step) begin
                    if (mode == 2'b01) m_off[k] = (m_off[k] + 1) % MSG_COLS;
                    else if (mode == 2'b10) m_off[k] = (m_off[k] + MSG_COLS - 1) % MSG_COLS;
                    else if (mode == 2'b11) m_blank[k] = !m_blank[k];
                end
                if (mode != 2'b11) m_blank[k] = 1'b0;
                m_cyc[k] = m_cyc[k] + 1;
            end
            if (wr_en) m_buf[wr_addr] = wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model L a",      32'(l_a),   32'(m_l[0]));
            check("model C a",      32'(c_a),   32'(m_c[0]));
            check("model tick a",   32'(ft_a),  32'(m_ft[0]));
            check("model offset a", 32'(off_a), 32'(m_off[0]));
            check("model L b",      32'(l_b),   32'(m_l[1]));
            check("model C b",      32'(c_b),   32'(m_c[1]));
            check("model tick b",   32'(ft_b),  32'(m_ft[1]));
            check("model offset b", 32'(off_b), 32'(m_off[1]));
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_to(input int t);
        if (t > edges) run(t - edges);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; wr_en = 1'b0; mode = 2'b00;
        repeat (n) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        edges = 0;
    endtask

    task automatic write_col(input int addr, input logic [4:0] data);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_data = data;
        run(1);
        wr_en = 1'b0;
    endtask

    vec_t vecs[6];
    int   ft_count;

    initial begin
        vecs[0] = '{mode: 2'b00, mask: 8'h01, steps: 5, exp_off: 0, exp_c: 7'b0000001};
        vecs[1] = '{mode: 2'b01, mask: 8'h02, steps: 1, exp_off: 1, exp_c: 7'b0000001};
        vecs[2] = '{mode: 2'b01, mask: 8'h02, steps: 8, exp_off: 0, exp_c: 7'b0000010};
        vecs[3] = '{mode: 2'b10, mask: 8'h01, steps: 1, exp_off: 7, exp_c: 7'b0000010};
        vecs[4] = '{mode: 2'b10, mask: 8'h01, steps: 3, exp_off: 5, exp_c: 7'b0001000};
        vecs[5] = '{mode: 2'b01, mask: 8'h40, steps: 3, exp_off: 3, exp_c: 7'b0001000};

        // Reset hold and release
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset L", 32'(l_a), 32'h0);
        check("reset C", 32'(c_a), 32'h0);
        check("reset tick", 32'(ft_a), 32'h0);
        check("reset offset", 32'(off_a), 32'h0);
        rst = 1'b0; edges = 0;
        run(1);
        check("first row L", 32'(l_a), 32'h01);
        run(4);
        check("second row L", 32'(l_a), 32'h02);
        ft_count = 0;
        repeat (100) begin
            run(1);
            if (ft_a) ft_count++;
        end
        check("frame ticks per 100 cycles", 32'(ft_count), 32'd5);
        $display("reset sequence: L=%b frame_ticks=%0d", l_a, ft_count);

        // Static: only row 0 lights column 0
        do_reset(2);
        write_col(0, 5'b00001);
        run_to(6);
        check("static row1 C", 32'(c_a), 32'h0);
        check("static row1 L", 32'(l_a), 32'h02);
        run_to(21);
        check("static row0 C", 32'(c_a), 32'h01);
        $display("static rows: C=%b L=%b", c_a, l_a);

        for (int v = 0; v < 6; v++) begin
            do_reset(2);
            for (int c = 0; c < MSG_COLS; c++)
                if (vecs[v].mask[c]) write_col(c, 5'b00001);
            mode = vecs[v].mode;
            run_to(FRAME * vecs[v].steps + 2);
            check("vector offset", 32'(off_a), 32'(vecs[v].exp_off));
            check("vector C", 32'(c_a), 32'(vecs[v].exp_c));
            check("vector L", 32'(l_a), 32'h01);
            $display("vector %0d: mode=%0d steps=%0d offset=%0d C=%b", v, vecs[v].mode,
                     vecs[v].steps, off_a, c_a);
        end

        // Blink on the STEP_DIV=2 instance, then back to static
        do_reset(2);
        for (int c = 0; c < MSG_COLS; c++) write_col(c, 5'b11111);
        mode = 2'b11;
        run_to(30);
        check("blink on C", 32'(c_b), 32'h7f);
        check("blink on L", 32'(l_b), 32'h04);
        run_to(42);
        check("blink off C", 32'(c_b), 32'h0);
        run_to(62);
        check("blink off frame2 C", 32'(c_b), 32'h0);
        run_to(82);
        check("blink on again C", 32'(c_b), 32'h7f);
        run_to(122);
        check("blink off again C", 32'(c_b), 32'h0);
        run_to(125);
        mode = 2'b00;
        run_to(162);
        check("blink to static C", 32'(c_b), 32'h7f);
        $display("blink sequence: C=%b L=%b", c_b, l_b);

        // Reset mid-scroll colliding with a write
        do_reset(2);
        write_col(2, 5'b00001);
        mode = 2'b01;
        run_to(FRAME * 5 + 2);
        check("mid-scroll offset", 32'(off_a), 32'd5);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'b11111;
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; edges = 0;
        check("collision offset", 32'(off_a), 32'h0);
        check("collision C", 32'(c_a), 32'h0);
        check("collision L", 32'(l_a), 32'h0);
        run(1);
        check("after collision L", 32'(l_a), 32'h01);
        check("after collision C", 32'(c_a), 32'h0);
        run_to(FRAME + 2);
        check("discarded write C", 32'(c_a), 32'h0);
        $display("reset collision: offset=%0d C=%b", off_a, c_a);

        // Randomized traffic against the model
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, MSG_COLS - 1));
            wr_data = 5'($urandom);
            rst     = ($urandom_range(0, 499) == 0);
            run(1);
        end
        rst = 1'b0; wr_en = 1'b0;
        run(1);
        $display("random phase: final offsets %0d/%0d", off_a, off_b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
